// File: rtl/lc3_decode_stage.sv
// ---------------------------------------------------------------------------
// lc3_decode_stage
//
// Registered decode stage of the LC-3 pipeline. On every rising clock edge
// with enable_decode high (and reset low) it captures the fetched instruction
// and its next-PC, and decodes the execute / writeback / memory control words
// directly from the incoming instruction word. All outputs are registers and
// hold their values while enable_decode is low, except decode_valid, which
// pulses for exactly one cycle per capture.
//
// Ports:
//   clock          in   sole clock, rising-edge
//   reset          in   synchronous active-high reset, priority over capture
//   enable_decode  in   capture strobe from fetch
//   dout[15:0]     in   instruction word from instruction memory
//   npc_in[15:0]   in   PC+1 of the instruction on dout
//   IR[15:0]       out  latched instruction
//   npc_out[15:0]  out  latched npc_in
//   E_Control[5:0] out  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_Control[1:0] out  00 ALU/none, 01 memory data, 10 computed PC address
//   Mem_Control    out  1 = indirect access (LDI/STI)
//   decode_valid   out  one-cycle pulse after each capture
//   illegal_op     out  captured opcode is unsupported
// ---------------------------------------------------------------------------
module lc3_decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        decode_valid,
  output logic        illegal_op
);

  // Decoded control fields for the instruction currently on dout
  logic [1:0]  alu_s;
  logic [1:0]  pcsel1_s;
  logic        pcsel2_s;
  logic        op2sel_s;
  logic [1:0]  wsel_s;
  logic        mem_s;
  logic        illegal_s;

  // Output registers and their next-state values
  logic [15:0] ir_q,      ir_d;
  logic [15:0] npc_q,     npc_d;
  logic [5:0]  e_ctrl_q,  e_ctrl_d;
  logic [1:0]  w_ctrl_q,  w_ctrl_d;
  logic        mem_q,     mem_d;
  logic        valid_q,   valid_d;
  logic        illegal_q, illegal_d;

  // Opcode decode of the incoming instruction word (not of IR)
  always_comb begin
    alu_s     = 2'b00;
    pcsel1_s  = 2'b00;
    pcsel2_s  = 1'b0;
    op2sel_s  = 1'b0;
    wsel_s    = 2'b00;
    mem_s     = 1'b0;
    illegal_s = 1'b0;
    case (dout[15:12])
      4'b0001: begin                       // ADD: bit 5 set means imm5
        op2sel_s = ~dout[5];
      end
      4'b0101: begin                       // AND
        alu_s    = 2'b01;
        op2sel_s = ~dout[5];
      end
      4'b1001: begin                       // NOT
        alu_s = 2'b10;
      end
      4'b0000: begin                       // BR
        pcsel1_s = 2'b01;
        pcsel2_s = 1'b1;
      end
      4'b1100: begin                       // JMP: base register + zero
        pcsel1_s = 2'b11;
      end
      4'b0010: begin                       // LD
        pcsel1_s = 2'b01;
        pcsel2_s = 1'b1;
        wsel_s   = 2'b01;
      end
      4'b0110: begin                       // LDR
        pcsel1_s = 2'b10;
        wsel_s   = 2'b01;
      end
      4'b1010: begin                       // LDI
        pcsel1_s = 2'b01;
        pcsel2_s = 1'b1;
        wsel_s   = 2'b01;
        mem_s    = 1'b1;
      end
      4'b1110: begin                       // LEA
        pcsel1_s = 2'b01;
        pcsel2_s = 1'b1;
        wsel_s   = 2'b10;
      end
      4'b0011: begin                       // ST
        pcsel1_s = 2'b01;
        pcsel2_s = 1'b1;
      end
      4'b0111: begin                       // STR
        pcsel1_s = 2'b10;
      end
      4'b1011: begin                       // STI
        pcsel1_s = 2'b01;
        pcsel2_s = 1'b1;
        mem_s    = 1'b1;
      end
      default: begin                       // 0100, 1000, 1101, 1111
        illegal_s = 1'b1;
      end
    endcase
  end

  // Next-state selection: capture on enable, otherwise hold (valid drops)
  always_comb begin
    ir_d      = ir_q;
    npc_d     = npc_q;
    e_ctrl_d  = e_ctrl_q;
    w_ctrl_d  = w_ctrl_q;
    mem_d     = mem_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    if (enable_decode) begin
      ir_d      = dout;
      npc_d     = npc_in;
      e_ctrl_d  = {alu_s, pcsel1_s, pcsel2_s, op2sel_s};
      w_ctrl_d  = wsel_s;
      mem_d     = mem_s;
      illegal_d = illegal_s;
      valid_d   = 1'b1;
    end else begin
      valid_d   = 1'b0;
    end
  end

  // Output registers with synchronous reset taking priority over capture
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q      <= 16'h0000;
      npc_q     <= 16'h0000;
      e_ctrl_q  <= 6'b000000;
      w_ctrl_q  <= 2'b00;
      mem_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      e_ctrl_q  <= e_ctrl_d;
      w_ctrl_q  <= w_ctrl_d;
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_ctrl_q;
  assign W_Control    = w_ctrl_q;
  assign Mem_Control  = mem_q;
  assign decode_valid = valid_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_lc3_decode_stage
//
// Self-checking bench for lc3_decode_stage. A behavioural model built from
// the instruction table tracks the expected outputs; a compare process checks
// every output after every rising edge. Directed scenarios add hand-computed
// literal checks, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  lc3_decode_stage dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .decode_valid  (decode_valid),
    .illegal_op    (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction table: one row per opcode
  typedef struct packed {
    logic       legal;
    logic [1:0] alu;
    logic [1:0] ps1;
    logic       ps2;
    logic       uses_bit5;   // op2select = ~instr[5]
    logic [1:0] w;
    logic       m;
  } ent_t;

  ent_t tbl [16];

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    //            legal alu    ps1    ps2   bit5  w      m
    tbl[4'h1] = {1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0}; // ADD
    tbl[4'h5] = {1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0}; // AND
    tbl[4'h9] = {1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0}; // NOT
    tbl[4'h0] = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0}; // BR
    tbl[4'hC] = {1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0}; // JMP
    tbl[4'h2] = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0}; // LD
    tbl[4'h6] = {1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd1, 1'b0}; // LDR
    tbl[4'hA] = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1}; // LDI
    tbl[4'hE] = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0}; // LEA
    tbl[4'h3] = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0}; // ST
    tbl[4'h7] = {1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0}; // STR
    tbl[4'hB] = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1}; // STI
  end

  // Model state
  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_v, m_ill;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update on each edge, then compare all outputs shortly after it
  always @(posedge clock) begin
    ent_t e;
    if (reset) begin
      m_ir = 16'h0; m_npc = 16'h0; m_e = 6'h0; m_w = 2'h0;
      m_m = 1'b0; m_v = 1'b0; m_ill = 1'b0;
    end else if (enable_decode) begin
      e     = tbl[dout[15:12]];
      m_ir  = dout;
      m_npc = npc_in;
      m_v   = 1'b1;
      m_ill = ~e.legal;
      m_e   = {e.alu, e.ps1, e.ps2, e.uses_bit5 & ~dout[5]};
      m_w   = e.w;
      m_m   = e.m;
    end else begin
      m_v = 1'b0;
    end
    #1;
    chk("IR",           IR,                    m_ir);
    chk("npc_out",      npc_out,               m_npc);
    chk("E_Control",    {10'h0, E_Control},    {10'h0, m_e});
    chk("W_Control",    {14'h0, W_Control},    {14'h0, m_w});
    chk("Mem_Control",  {15'h0, Mem_Control},  {15'h0, m_m});
    chk("decode_valid", {15'h0, decode_valid}, {15'h0, m_v});
    chk("illegal_op",   {15'h0, illegal_op},   {15'h0, m_ill});
  end

  // Apply inputs at a falling edge; return at the next falling edge
  task automatic cyc(input logic r, input logic en, input logic [15:0] d, input logic [15:0] n);
    reset = r; enable_decode = en; dout = d; npc_in = n;
    @(negedge clock);
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk({"lit_", name}, act, exp);
  endtask

  initial begin
    reset = 1'b1; enable_decode = 1'b0; dout = 16'h0; npc_in = 16'h0;
    @(negedge clock);
    cyc(1'b1, 1'b0, 16'h0, 16'h0);
    lit("reset_IR", IR, 16'h0);
    lit("reset_valid", {15'h0, decode_valid}, 16'h0);

    // Register-mode ADD
    cyc(1'b0, 1'b1, 16'h1283, 16'h3001);
    lit("add_IR", IR, 16'h1283);
    lit("add_npc", npc_out, 16'h3001);
    lit("add_E", {10'h0, E_Control}, 16'h0001);
    lit("add_W", {14'h0, W_Control}, 16'h0000);
    lit("add_valid", {15'h0, decode_valid}, 16'h0001);
    cyc(1'b0, 1'b0, 16'h0, 16'h0);
    lit("add_valid_drop", {15'h0, decode_valid}, 16'h0000);
    lit("add_hold_IR", IR, 16'h1283);

    // Immediate ADD then LDR back to back
    cyc(1'b0, 1'b1, 16'h1262, 16'h3002);
    lit("addi_E", {10'h0, E_Control}, 16'h0000);
    lit("addi_valid", {15'h0, decode_valid}, 16'h0001);
    cyc(1'b0, 1'b1, 16'h64C5, 16'h3003);
    lit("ldr_E", {10'h0, E_Control}, 16'h0008);
    lit("ldr_W", {14'h0, W_Control}, 16'h0001);
    lit("ldr_valid", {15'h0, decode_valid}, 16'h0001);

    // Indirect load
    cyc(1'b0, 1'b1, 16'hA1FF, 16'h3010);
    lit("ldi_E", {10'h0, E_Control}, 16'h0006);
    lit("ldi_W", {14'h0, W_Control}, 16'h0001);
    lit("ldi_M", {15'h0, Mem_Control}, 16'h0001);
    lit("ldi_npc", npc_out, 16'h3010);

    // LEA then hold with random inputs
    cyc(1'b0, 1'b1, 16'hE005, 16'h3020);
    lit("lea_W", {14'h0, W_Control}, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      lit("hold_IR", IR, 16'hE005);
      lit("hold_npc", npc_out, 16'h3020);
      lit("hold_W", {14'h0, W_Control}, 16'h0002);
      lit("hold_valid", {15'h0, decode_valid}, 16'h0000);
    end

    // Illegal opcode then legal AND immediate
    cyc(1'b0, 1'b1, 16'hD000, 16'h3030);
    lit("ill_IR", IR, 16'hD000);
    lit("ill_flag", {15'h0, illegal_op}, 16'h0001);
    lit("ill_E", {10'h0, E_Control}, 16'h0000);
    lit("ill_W", {14'h0, W_Control}, 16'h0000);
    lit("ill_valid", {15'h0, decode_valid}, 16'h0001);
    cyc(1'b0, 1'b1, 16'h5020, 16'h3031);
    lit("and_ill_clr", {15'h0, illegal_op}, 16'h0000);
    lit("and_E", {10'h0, E_Control}, 16'h0010);

    // Reset colliding with capture
    cyc(1'b1, 1'b1, 16'h1283, 16'h3040);
    lit("coll_IR", IR, 16'h0000);
    lit("coll_npc", npc_out, 16'h0000);
    lit("coll_E", {10'h0, E_Control}, 16'h0000);
    lit("coll_valid", {15'h0, decode_valid}, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b1, 16'h1283, 16'h3041);
    lit("post_IR", IR, 16'h1283);
    lit("post_E", {10'h0, E_Control}, 16'h0001);
    lit("post_valid", {15'h0, decode_valid}, 16'h0001);

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
          16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
